// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset release sequencer.
//   seq_state_e      : sequencer FSM states
//   MIN_SYNC_STAGES  : smallest legal release synchronizer depth
package reset_seq_pkg;

  localparam int unsigned MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/reset_sync.sv
// Reset release synchronizer: asynchronous clear, synchronous release.
// A constant 1 shifts through STAGES flops after rst falls.
//   clk   : destination clock
//   rst   : raw asynchronous active-high reset
//   ready : high STAGES-1 edges after the first edge following rst release
module reset_sync #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  output logic ready
);

  logic [STAGES-1:0] chain;

  // Shift register; clearing is asynchronous, the 1 only enters on clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign ready = chain[STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: asserts a bank of reset outputs immediately on the
// raw reset and releases them one at a time, in index order, D+1 clock edges
// apart. A software request from DONE reruns the release sequence.
//   clk        : clock
//   rst        : raw asynchronous active-high reset
//   sw_rst_req : single-cycle software reset request (honoured only in DONE)
//   delay_i    : spacing D, sampled at every counter load
//   rst_o      : registered active-high reset outputs
//   busy       : high while any rst_o bit is asserted
//   done       : high once every rst_o bit is released
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned DELAY_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  input  logic [DELAY_W-1:0] delay_i,
  output logic [NUM_OUT-1:0] rst_o,
  output logic               busy,
  output logic               done
);

  localparam int unsigned IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] BIT0 = NUM_OUT'(1);

  // Elaboration-time parameter sanity checks.
  generate
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
      $error("reset_release_sequencer: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
    end
    if (NUM_OUT < 1) begin : g_bad_num
      $error("reset_release_sequencer: NUM_OUT must be at least 1");
    end
  endgenerate

  logic               ready;
  seq_state_e         state;
  logic [IDX_W-1:0]   idx;
  logic [DELAY_W-1:0] cnt;

  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .ready (ready)
  );

  // Sequencer FSM with its index, spacing counter and output bank.
  // Outputs only ever clear on a clock edge; assertion comes from rst directly
  // or from an accepted software request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_HOLD;
      idx   <= '0;
      cnt   <= '0;
      rst_o <= '1;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      unique case (state)
        ST_HOLD: begin
          if (ready) begin
            cnt   <= delay_i;
            idx   <= '0;
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (cnt != '0) begin
            cnt <= cnt - DELAY_W'(1);
          end else begin
            rst_o <= rst_o & ~(BIT0 << idx);
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
              cnt <= delay_i;
            end
          end
        end
        ST_DONE: begin
          // Software re-reset bypasses the synchronizer: rst is not involved.
          if (sw_rst_req) begin
            rst_o <= '1;
            done  <= 1'b0;
            busy  <= 1'b1;
            idx   <= '0;
            cnt   <= delay_i;
            state <= ST_COUNT;
          end
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

endmodule
